// File: rtl/selfcheck_pkg.sv
// Shared types for the commit self-check monitor.
// No logic and no latency; only the state encoding, the commit record and register-file constants.
// No flow control here; consumers are passive taps.
package selfcheck_pkg;

  // RISC-V integer register file size and the index width it implies.
  localparam int NUM_ARCH_REGS = 32;
  localparam int RD_W          = $clog2(NUM_ARCH_REGS);

  // Default datapath width of the RV32 core, used for the packed commit view.
  localparam int PKG_XLEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } state_t;

  // One architectural register commit: destination and written value.
  typedef struct packed {
    logic [RD_W-1:0]     rd;
    logic [PKG_XLEN-1:0] data;
  } commit_t;

endpackage

// File: rtl/selfcheck_expect_mem.sv
// Expected-commit table: DEPTH entries of {rd, data}, one write port, one async read port.
// Write lands at the clock edge; read is combinational on raddr (zero-cycle).
// No backpressure; writes are always accepted when we is high.
//
// Ports:
//   clk            write clock
//   we/waddr       write enable and entry index
//   wrd/wdata      entry contents to store
//   raddr          read index
//   rrd/rdata      entry contents at raddr (combinational)
module selfcheck_expect_mem
  import selfcheck_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [RD_W-1:0]          wrd,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [RD_W-1:0]          rrd,
  output logic [XLEN-1:0]          rdata
);

  // Table contents are deliberately not reset so a program can be reused
  // across resets and restarts.
  logic [RD_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      rd_mem[waddr]   <= wrd;
      data_mem[waddr] <= wdata;
    end
  end

  // Asynchronous read so a commit in the first RUN cycle sees entry 0.
  assign rrd   = rd_mem[raddr];
  assign rdata = data_mem[raddr];

endmodule

// File: rtl/commit_selfcheck_monitor.sv
// Checks the core's ordered register-commit stream against a programmed table; reports pass/mismatch/timeout.
// Status and statistics are registered: they update one cycle after the deciding commit or cycle.
// No backpressure; a passive tap on the writeback port that never stalls the core.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   cfg_we/cfg_addr/cfg_rd/cfg_data   table write (dropped while busy)
//   cfg_len                           number of valid entries, sampled on start
//   start                             begin/restart a run (ignored while busy)
//   wb_RegWrite/wb_rd/wb_data, stall  core writeback tap and hazard stall
//   busy/done/pass/fail_mismatch/fail_timeout  run status
//   fail_idx/got_rd/got_data          offending entry index and commit
//   cycle_count/stall_count/commit_count  saturating run statistics
module commit_selfcheck_monitor
  import selfcheck_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [RD_W-1:0]          cfg_rd,
  input  logic [XLEN-1:0]          cfg_data,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic                     start,
  input  logic                     wb_RegWrite,
  input  logic [RD_W-1:0]          wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail_mismatch,
  output logic                     fail_timeout,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic [RD_W-1:0]          got_rd,
  output logic [XLEN-1:0]          got_data,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         stall_count,
  output logic [CNT_W-1:0]         commit_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // Separate run timer so the timeout still fires when TIMEOUT_CYCLES
  // exceeds what the saturating statistic counter can represent.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q,   ptr_d;
  logic [LW-1:0]     len_q,   len_d;
  logic [TW-1:0]     tmr_q,   tmr_d;
  logic [CNT_W-1:0]  cyc_q,   cyc_d;
  logic [CNT_W-1:0]  stl_q,   stl_d;
  logic [CNT_W-1:0]  cmt_q,   cmt_d;
  logic [AW-1:0]     fidx_q,  fidx_d;
  logic [RD_W-1:0]   grd_q,   grd_d;
  logic [XLEN-1:0]   gdat_q,  gdat_d;

  logic              tbl_we;
  logic [RD_W-1:0]   exp_rd;
  logic [XLEN-1:0]   exp_data;
  logic              commit;
  logic              hit;
  logic              last;
  logic              tmo;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Table writes are locked out only while a run is consuming the table;
  // a write in the start cycle lands before the first RUN read.
  assign tbl_we = cfg_we && (state_q != RUN);

  selfcheck_expect_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_expect_mem (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wrd   (cfg_rd),
    .wdata (cfg_data),
    .raddr (ptr_q),
    .rrd   (exp_rd),
    .rdata (exp_data)
  );

  // Writes to x0 are architecturally invisible, so they are neither
  // compared nor counted.
  assign commit = wb_RegWrite && (wb_rd != '0);
  assign hit    = commit && (wb_rd == exp_rd) && (wb_data == exp_data);
  assign last   = ({1'b0, ptr_q} == (len_q - LW'(1)));
  assign tmo    = (tmr_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    tmr_d   = tmr_q;
    cyc_d   = cyc_q;
    stl_d   = stl_q;
    cmt_d   = cmt_q;
    fidx_d  = fidx_q;
    grd_d   = grd_q;
    gdat_d  = gdat_q;

    case (state_q)
      RUN: begin
        // Priority: completing match, then mismatch, then timeout.
        if (hit && last) begin
          state_d = PASS;
          cmt_d   = sat_inc(cmt_q);
          cyc_d   = sat_inc(cyc_q);
          if (stall) stl_d = sat_inc(stl_q);
        end else if (commit && !hit) begin
          state_d = FAIL;
          fidx_d  = ptr_q;
          grd_d   = wb_rd;
          gdat_d  = wb_data;
          cyc_d   = sat_inc(cyc_q);
          if (stall) stl_d = sat_inc(stl_q);
        end else begin
          if (hit) begin
            ptr_d = ptr_q + AW'(1);
            cmt_d = sat_inc(cmt_q);
          end
          if (tmo) begin
            // The deciding timeout cycle is not added to the statistics,
            // so cycle_count reads TIMEOUT_CYCLES-1 afterwards.
            state_d = TIMEOUT;
            fidx_d  = ptr_d;
          end else begin
            tmr_d = tmr_q + TW'(1);
            cyc_d = sat_inc(cyc_q);
            if (stall) stl_d = sat_inc(stl_q);
          end
        end
      end

      default: begin
        // IDLE and all terminal states: wait for (re)start.
        if (start) begin
          ptr_d   = '0;
          tmr_d   = '0;
          cyc_d   = '0;
          stl_d   = '0;
          cmt_d   = '0;
          fidx_d  = '0;
          grd_d   = '0;
          gdat_d  = '0;
          len_d   = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
          state_d = (cfg_len == '0) ? PASS : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      tmr_q   <= '0;
      cyc_q   <= '0;
      stl_q   <= '0;
      cmt_q   <= '0;
      fidx_q  <= '0;
      grd_q   <= '0;
      gdat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      tmr_q   <= tmr_d;
      cyc_q   <= cyc_d;
      stl_q   <= stl_d;
      cmt_q   <= cmt_d;
      fidx_q  <= fidx_d;
      grd_q   <= grd_d;
      gdat_q  <= gdat_d;
    end
  end

  // Status flags get their own flops, loaded from the next state, so they
  // line up with the state register without decode logic on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_mismatch <= 1'b0;
      fail_timeout  <= 1'b0;
    end else begin
      busy          <= (state_d == RUN);
      done          <= (state_d == PASS) || (state_d == FAIL) || (state_d == TIMEOUT);
      pass          <= (state_d == PASS);
      fail_mismatch <= (state_d == FAIL);
      fail_timeout  <= (state_d == TIMEOUT);
    end
  end

  assign fail_idx     = fidx_q;
  assign got_rd       = grd_q;
  assign got_data     = gdat_q;
  assign cycle_count  = cyc_q;
  assign stall_count  = stl_q;
  assign commit_count = cmt_q;

endmodule

// File: tb/tb_commit_selfcheck_monitor.sv
// Randomized and directed bench for commit_selfcheck_monitor against a stream-level reference model.
// Latency checked: status one cycle after the deciding commit; timeout TIMEOUT_CYCLES cycles after start.
// The monitor is passive, so the bench drives writeback freely with no backpressure.
module tb_commit_selfcheck_monitor;
  import selfcheck_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int TMO   = 20;
  localparam int CNT_W = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int NCYC  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [4:0]       cfg_rd;
  logic [XLEN-1:0]  cfg_data;
  logic [LW-1:0]    cfg_len;
  logic             start;
  logic             wb_RegWrite;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             stall;
  logic             busy, done, pass, fail_mismatch, fail_timeout;
  logic [AW-1:0]    fail_idx;
  logic [4:0]       got_rd;
  logic [XLEN-1:0]  got_data;
  logic [CNT_W-1:0] cycle_count, stall_count, commit_count;

  always #5 clk = ~clk;

  commit_selfcheck_monitor #(
    .XLEN           (XLEN),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_rd        (cfg_rd),
    .cfg_data      (cfg_data),
    .cfg_len       (cfg_len),
    .start         (start),
    .wb_RegWrite   (wb_RegWrite),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .stall         (stall),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_mismatch (fail_mismatch),
    .fail_timeout  (fail_timeout),
    .fail_idx      (fail_idx),
    .got_rd        (got_rd),
    .got_data      (got_data),
    .cycle_count   (cycle_count),
    .stall_count   (stall_count),
    .commit_count  (commit_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model view of the table, the table to be programmed, and per-cycle stimulus.
  commit_t mdl_tbl [DEPTH];
  commit_t new_tbl [DEPTH];
  logic    st_we    [NCYC];
  commit_t st_c     [NCYC];
  logic    st_stall [NCYC];

  // Model predictions.
  int          m_outcome;  // 0 pass, 1 mismatch, 2 timeout
  int          m_dc;       // cycles after the start edge until done
  int          m_fidx, m_cyc, m_stl, m_cmt;
  logic [4:0]  m_grd;
  logic [31:0] m_gdat;

  // Walk the commit stream in order: the i-th real commit must equal table
  // entry i; the run gets TMO cycles, the last of which does not count.
  task automatic model_run(input int len_in);
    int len, idx, stl;
    bit cm, ok;
    len = (len_in > DEPTH) ? DEPTH : len_in;
    idx = 0; stl = 0;
    m_fidx = 0; m_cyc = 0; m_stl = 0; m_cmt = 0; m_grd = '0; m_gdat = '0;
    m_outcome = 0; m_dc = 0;
    if (len == 0) return;
    for (int k = 0; k < TMO; k++) begin
      cm = st_we[k] && (st_c[k].rd != 0);
      ok = cm && (st_c[k] == mdl_tbl[idx]);
      if (ok && idx == len - 1) begin
        m_outcome = 0; m_dc = k + 1; m_cmt = len; m_cyc = k + 1; m_stl = stl + int'(st_stall[k]);
        return;
      end
      if (cm && !ok) begin
        m_outcome = 1; m_dc = k + 1; m_fidx = idx; m_grd = st_c[k].rd; m_gdat = st_c[k].data;
        m_cmt = idx; m_cyc = k + 1; m_stl = stl + int'(st_stall[k]);
        return;
      end
      if (ok) idx++;
      if (k == TMO - 1) begin
        m_outcome = 2; m_dc = k + 1; m_fidx = idx; m_cmt = idx; m_cyc = k; m_stl = stl;
        return;
      end
      stl += int'(st_stall[k]);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < NCYC; k++) begin
      st_we[k] = 1'b0; st_c[k] = '0; st_stall[k] = 1'b0;
    end
  endtask

  task automatic put(input int k, input logic [4:0] rd, input logic [31:0] data);
    st_we[k] = 1'b1; st_c[k].rd = rd; st_c[k].data = data;
  endtask

  task automatic drive_idle();
    wb_RegWrite = 1'b0; wb_rd = '0; wb_data = '0; stall = 1'b0;
  endtask

  task automatic drive_cycle(input int k);
    if (k < NCYC) begin
      wb_RegWrite = st_we[k]; wb_rd = st_c[k].rd; wb_data = st_c[k].data; stall = st_stall[k];
    end else begin
      drive_idle();
    end
  endtask

  // Program entries 0..n_wr-1; the last write shares its cycle with start.
  task automatic load_and_start(input int n_wr, input int len_in);
    for (int i = 0; i < n_wr; i++) begin
      cfg_we = 1'b1; cfg_addr = AW'(i); cfg_rd = new_tbl[i].rd; cfg_data = new_tbl[i].data;
      mdl_tbl[i] = new_tbl[i];
      if (i == n_wr - 1) begin start = 1'b1; cfg_len = LW'(len_in); end
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
    if (n_wr == 0) begin
      start = 1'b1; cfg_len = LW'(len_in);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic run_case(input string name, input int n_wr, input int len_in, input bit wr_during);
    int dc;
    bit seen, busy0, done0;
    load_and_start(n_wr, len_in);
    busy0 = busy; done0 = done;
    model_run(len_in);
    seen = done0; dc = done0 ? 0 : -1;
    for (int k = 0; k < NCYC && !seen; k++) begin
      drive_cycle(k);
      if (wr_during && k == 0) begin
        cfg_we = 1'b1; cfg_addr = AW'(2); cfg_rd = 5'd3; cfg_data = 32'h99;
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (done) begin seen = 1'b1; dc = k + 1; end
    end
    drive_idle();
    check_eq({name, ".busy_at_start"}, busy0, (len_in != 0));
    check_eq({name, ".done_cycle"}, dc, m_dc);
    check_eq({name, ".pass"}, pass, (m_outcome == 0));
    check_eq({name, ".fail_mismatch"}, fail_mismatch, (m_outcome == 1));
    check_eq({name, ".fail_timeout"}, fail_timeout, (m_outcome == 2));
    check_eq({name, ".fail_idx"}, fail_idx, m_fidx);
    check_eq({name, ".got_rd"}, got_rd, m_grd);
    check_eq({name, ".got_data"}, got_data, m_gdat);
    check_eq({name, ".cycle_count"}, cycle_count, m_cyc);
    check_eq({name, ".stall_count"}, stall_count, m_stl);
    check_eq({name, ".commit_count"}, commit_count, m_cmt);
    // Terminal state and statistics must hold with start low.
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive_idle();
    check_eq({name, ".hold_status"}, {busy, done, pass, fail_mismatch, fail_timeout},
             {1'b0, 1'b1, m_outcome == 0, m_outcome == 1, m_outcome == 2});
    check_eq({name, ".hold_counts"}, {cycle_count, stall_count, commit_count},
             {CNT_W'(m_cyc), CNT_W'(m_stl), CNT_W'(m_cmt)});
  endtask

  task automatic set_tbl3();
    new_tbl[0] = '{rd: 5'd1, data: 32'd6};
    new_tbl[1] = '{rd: 5'd2, data: 32'd4};
    new_tbl[2] = '{rd: 5'd3, data: 32'd24};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len, pos, gap, r;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_rd = '0; cfg_data = '0; cfg_len = '0;
    start = 1'b0;
    drive_idle();
    for (int i = 0; i < DEPTH; i++) mdl_tbl[i] = '0;
    #1;
    check_eq("reset.status", {busy, done, pass, fail_mismatch, fail_timeout}, 5'b0);
    check_eq("reset.regs", {fail_idx, got_rd, got_data, cycle_count, stall_count, commit_count}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic pass, first commit in the first RUN cycle.
    set_tbl3(); clear_stim();
    put(0, 1, 6); put(1, 2, 4); put(2, 3, 32'h18);
    run_case("t1_pass", 3, 3, 0);
    check_eq("t1_pass.count_const", commit_count, 3);

    // Mismatch on the third commit.
    clear_stim();
    put(0, 1, 6); put(1, 2, 4); put(2, 3, 32'h19);
    run_case("t2_mismatch", 0, 3, 0);
    check_eq("t2_mismatch.got_const", {fail_idx, got_rd, got_data}, {AW'(2), 5'd3, 32'h19});

    // Timeout: third commit never arrives.
    clear_stim();
    put(0, 1, 6); put(1, 2, 4);
    run_case("t3_timeout", 0, 3, 0);
    check_eq("t3_timeout.const", {fail_idx, cycle_count}, {AW'(2), CNT_W'(19)});

    // x0 writes and six stall cycles between commits.
    clear_stim();
    put(0, 1, 6); put(4, 2, 4); put(8, 3, 24);
    put(2, 0, 32'hDEAD); put(6, 0, 32'hDEAD);
    for (int k = 1; k <= 7; k++) if (k != 4) st_stall[k] = 1'b1;
    run_case("t4_x0_stall", 0, 3, 0);
    check_eq("t4_x0_stall.const", {commit_count, stall_count}, {CNT_W'(3), CNT_W'(6)});

    // Final match on the timeout cycle wins.
    clear_stim();
    put(0, 1, 6); put(1, 2, 4); put(TMO - 1, 3, 24);
    run_case("t5_edge_pass", 0, 3, 0);
    check_eq("t5_edge_pass.const", {pass, fail_timeout}, 2'b10);

    // Reset mid-RUN aborts, then a restart reuses the retained table.
    clear_stim();
    put(0, 1, 6);
    load_and_start(0, 3);
    drive_cycle(0);
    @(posedge clk); #1;
    drive_idle();
    check_eq("t6_rst.pre_busy", {busy, commit_count}, {1'b1, CNT_W'(1)});
    rst = 1'b1; #1;
    check_eq("t6_rst.outputs", {busy, done, pass, fail_mismatch, fail_timeout, fail_idx,
                                got_rd, got_data, cycle_count, stall_count, commit_count}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_rst.idle", {busy, done}, 2'b00);
    clear_stim();
    put(0, 1, 6); put(1, 2, 4); put(2, 3, 24);
    run_case("t6_restart", 0, 3, 0);

    // Table write during RUN is dropped.
    clear_stim();
    put(0, 1, 6); put(1, 2, 4); put(2, 3, 24);
    run_case("t7_cfg_in_run", 0, 3, 1);
    check_eq("t7_cfg_in_run.const", pass, 1'b1);

    // Empty table passes immediately.
    clear_stim();
    run_case("t8_len0", 0, 0, 0);

    // Length above DEPTH clamps to DEPTH.
    clear_stim();
    for (int i = 0; i < DEPTH; i++) begin
      new_tbl[i].rd = 5'($urandom_range(1, 31)); new_tbl[i].data = $urandom;
      put(i, new_tbl[i].rd, new_tbl[i].data);
    end
    run_case("t9_clamp", DEPTH, DEPTH + 4, 0);
    check_eq("t9_clamp.const", commit_count, DEPTH);

    // Randomized programs with noise, stalls, gaps and occasional corruption.
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        new_tbl[i].rd = 5'($urandom_range(1, 31)); new_tbl[i].data = $urandom;
      end
      clear_stim();
      pos = 0;
      for (int e = 0; e < len && pos < NCYC; e++) begin
        gap = $urandom_range(0, 4);
        for (int g = 0; g < gap && pos < NCYC; g++) begin
          r = $urandom_range(0, 2);
          if (r == 1) put(pos, 0, $urandom);
          else if (r == 2) begin st_c[pos].rd = 5'($urandom_range(1, 31)); st_c[pos].data = $urandom; end
          pos++;
        end
        if (pos < NCYC) begin
          put(pos, new_tbl[e].rd, new_tbl[e].data);
          if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 0) st_c[pos].data = st_c[pos].data ^ (32'd1 << $urandom_range(0, 31));
            else st_c[pos].rd = st_c[pos].rd ^ 5'($urandom_range(1, 31));
          end
          pos++;
        end
      end
      for (int k = 0; k < NCYC; k++) st_stall[k] = ($urandom_range(0, 2) == 0);
      run_case($sformatf("rnd%0d", t), len, len, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/commit_selfcheck_monitor.md
Name: commit_selfcheck_monitor

Overview:
Synthesizable, parametrised self-checking monitor for the pipelined RV32IM core. It taps the core's writeback port (wb_RegWrite/wb_rd/wb_data) and stall signal. It compares the ordered stream of architectural register commits against a programmable expected-commit table, and reports pass, mismatch or timeout. Cycle, stall and commit statistics are provided for bench and FPGA bring-up use. It generalises the fixed three-register, fixed-cycle-budget check to any commit sequence, depth and timeout.

Parameters:
XLEN, 32, datapath/commit data width
DEPTH, 16, expected-commit table entries (power of two, >=2)
TIMEOUT_CYCLES, 1000, RUN cycles allowed before timeout (>=1)
CNT_W, 16, width of statistic counters (saturating)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  write one expected-table entry (honoured only when not in RUN)
cfg_addr  in  $clog2(DEPTH)  table index to write
cfg_rd  in  5  expected destination register for that entry
cfg_data  in  XLEN  expected write data for that entry
cfg_len  in  $clog2(DEPTH)+1  number of valid entries, sampled on start
start  in  1  begin or restart a check run
wb_RegWrite  in  1  core writeback enable
wb_rd  in  5  core writeback register index
wb_data  in  XLEN  core writeback data
stall  in  1  core hazard stall indicator
busy  out  1  state==RUN
done  out  1  state in {PASS, FAIL, TIMEOUT}
pass  out  1  state==PASS
fail_mismatch  out  1  state==FAIL
fail_timeout  out  1  state==TIMEOUT
fail_idx  out  $clog2(DEPTH)  table index of first mismatch, or pointer value at timeout
got_rd  out  5  rd of the offending commit
got_data  out  XLEN  data of the offending commit
cycle_count  out  CNT_W  cycles spent in RUN
stall_count  out  CNT_W  RUN cycles with stall=1
commit_count  out  CNT_W  matched commits

Behaviour:
- Reset: state IDLE, all outputs 0, internal ptr=0, len=0. Table contents are not reset. Reset asserted mid-RUN aborts immediately to IDLE.
- Commit qualifier: commit = wb_RegWrite && wb_rd!=0. Writes to x0 are never compared and never counted.
- IDLE or any terminal state, start=1:
  - Clear counters, fail_idx, got_* and ptr; latch len=cfg_len.
  - len==0 -> PASS next cycle.
  - len>DEPTH -> clamp len to DEPTH.
  - Otherwise -> RUN.
- Terminal states hold until start or rst. start in RUN is ignored.
- RUN, every cycle:
  - cycle_count++.
  - stall_count++ if stall=1.
  - Both counters saturate at all-ones.
- RUN commit matching against table[ptr]:
  - Match (rd and data equal): commit_count++, ptr++. If ptr==len-1 before the increment -> PASS.
  - Mismatch: capture fail_idx=ptr, got_rd, got_data -> FAIL. Counters freeze from the next cycle.
- Timeout: if cycle_count reaches TIMEOUT_CYCLES-1 in RUN without completion -> TIMEOUT, fail_idx=ptr.
- Priority within one cycle: final match > mismatch > timeout. A completing match on the timeout cycle gives PASS; a mismatch on the timeout cycle gives FAIL.
- cfg_we during RUN is dropped; the table is unchanged. cfg_we and start in the same cycle: the table write lands, and the run uses the new entry.
- All outputs are registered; status updates one cycle after the deciding commit.
- Table read is combinational or first-word-fall-through on ptr. A commit in the first RUN cycle must compare correctly.

Decomposition:
- Shared package selfcheck_pkg holds:
  - state enum {IDLE, RUN, PASS, FAIL, TIMEOUT}
  - commit struct {rd[4:0], data[XLEN-1:0]}
  - RISC-V register count constant (32)
- One sub-module: selfcheck_expect_mem, a DEPTH x (5+XLEN) table with one write port and one asynchronous read port.
- The FSM and counters stay in the top.

Test Plan:
- Table {x1=6, x2=4, x3=24}, len=3, commits x1=6, x2=4, x3=0x18 -> pass=1 one cycle after the x3 commit, commit_count=3, fail_*=0.
- Same table, third commit x3=0x19 -> fail_mismatch=1, fail_idx=2, got_rd=3, got_data=0x19, commit_count=2.
- TIMEOUT_CYCLES=20, only x1 and x2 commit -> fail_timeout=1 exactly 20 cycles after start, fail_idx=2, cycle_count=19.
- Interleave wb writes to x0 (data 0xDEAD) and 6 stall cycles between valid commits -> still pass, commit_count=3, stall_count=6.
- Final matching commit lands on the timeout cycle -> pass=1 and fail_timeout=0. Separately, rst pulsed mid-RUN -> all outputs 0 and state IDLE. A subsequent start with the table retained -> pass.
- cfg_we during RUN to index 2 with data 0x99 -> ignored, original x3=24 still checked, pass=1. len=0 with start -> pass next cycle.
